// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU CPU readback path: region codes, address map
// boundaries, STATUS bit positions and the address decoder.
package ppu_pkg;

   typedef enum logic [3:0] {
      REG_TGFX,
      REG_SGFX,
      REG_TBUF,
      REG_OAM,
      REG_PAL,
      REG_STATUS,
      REG_FRAME,
      REG_LINE,
      REG_NONE
   } region_e;

   // Word-address map; memory regions are contiguous from 0 up to the palette limit.
   localparam logic [15:0] TGFX_BASE   = 16'h0000;
   localparam logic [15:0] TGFX_LIMIT  = 16'h07FF;
   localparam logic [15:0] SGFX_BASE   = 16'h0800;
   localparam logic [15:0] SGFX_LIMIT  = 16'h0FFF;
   localparam logic [15:0] TBUF_BASE   = 16'h1000;
   localparam logic [15:0] TBUF_LIMIT  = 16'h11FF;
   localparam logic [15:0] OAM_BASE    = 16'h1200;
   localparam logic [15:0] OAM_LIMIT   = 16'h12FF;
   localparam logic [15:0] PAL_BASE    = 16'h1300;
   localparam logic [15:0] PAL_LIMIT   = 16'h1307;
   localparam logic [15:0] STATUS_ADDR = 16'h1400;
   localparam logic [15:0] FRAME_ADDR  = 16'h1401;
   localparam logic [15:0] LINE_ADDR   = 16'h1402;

   localparam int unsigned STATUS_PENDING_BIT = 0;
   localparam int unsigned STATUS_VBLANK_BIT  = 1;
   localparam int unsigned STATUS_OVERRUN_BIT = 2;

   // Ordered limit checks; each branch implies the address is above the previous limit.
   function automatic region_e decode_region(input logic [15:0] a);
      region_e r;
      if (a <= TGFX_LIMIT)       r = REG_TGFX;
      else if (a <= SGFX_LIMIT)  r = REG_SGFX;
      else if (a <= TBUF_LIMIT)  r = REG_TBUF;
      else if (a <= OAM_LIMIT)   r = REG_OAM;
      else if (a <= PAL_LIMIT)   r = REG_PAL;
      else if (a == STATUS_ADDR) r = REG_STATUS;
      else if (a == FRAME_ADDR)  r = REG_FRAME;
      else if (a == LINE_ADDR)   r = REG_LINE;
      else                       r = REG_NONE;
      return r;
   endfunction

endpackage

// File: rtl/ppu_vblank_irq.sv
// Vblank interrupt owner: rising-edge capture, pending/overrun flags with
// clear-on-read, and a wrapping frame counter.
module ppu_vblank_irq #(
   parameter int unsigned FRAME_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               vblank_i,
   input  logic               clear_i,
   output logic               pending_o,
   output logic               overrun_o,
   output logic [FRAME_W-1:0] frame_count_o
);

   logic               vblank_dly_q, vblank_dly_d;
   logic               armed_q, armed_d;
   logic               pending_q, pending_d;
   logic               overrun_q, overrun_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               rise;

   // Edge detect and flag update; a rise in the same cycle as a clear leaves pending set
   // but does not count as an overrun.
   always_comb begin
      vblank_dly_d = vblank_i;
      // armed_q blocks a false rise when vblank is already high as reset deasserts
      armed_d      = 1'b1;
      pending_d    = pending_q;
      overrun_d    = overrun_q;
      frame_d      = frame_q;
      rise         = vblank_i & ~vblank_dly_q & armed_q;
      if (clear_i) begin
         pending_d = 1'b0;
         overrun_d = 1'b0;
      end
      if (rise) begin
         pending_d = 1'b1;
         frame_d   = frame_q + FRAME_W'(1);
         if (pending_q && !clear_i) begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vblank_dly_q <= 1'b0;
         armed_q      <= 1'b0;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         frame_q      <= '0;
      end else begin
         vblank_dly_q <= vblank_dly_d;
         armed_q      <= armed_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         frame_q      <= frame_d;
      end
   end

   assign pending_o     = pending_q;
   assign overrun_o     = overrun_q;
   assign frame_count_o = frame_q;

endmodule

// File: rtl/ppu_cpu_readback.sv
// CPU-facing pipelined read slave for the PPU: fixed latency 2, one accept per cycle,
// reads the CPU ports of the PPU memories plus STATUS/FRAME_COUNT/LINE, drives irq.
module ppu_cpu_readback #(
   parameter int unsigned ADDR_W  = 13,
   parameter int unsigned FRAME_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic              read,
   input  logic [ADDR_W-1:0] address,
   output logic [31:0]       readdata,
   output logic              readdatavalid,
   output logic              irq,
   input  logic              vblank,
   input  logic [9:0]        vcount,
   output logic [8:0]        addr_tile_buffer,
   output logic [10:0]       addr_tile_graphics,
   output logic [10:0]       addr_sprite_graphics,
   output logic [7:0]        addr_OAM,
   output logic [2:0]        addr_color_palettes,
   input  logic [31:0]       rd_tile_buffer,
   input  logic [31:0]       rd_tile_graphics,
   input  logic [31:0]       rd_sprite_graphics,
   input  logic [31:0]       rd_OAM,
   input  logic [23:0]       rd_color_palettes
);

   import ppu_pkg::*;

   logic [15:0]        addr_w16;
   logic               rvalid_q, rvalid_d;
   region_e            region_q, region_d;
   logic [31:0]        readdata_q, readdata_d;
   logic               readdatavalid_q, readdatavalid_d;
   logic [31:0]        resp_data;
   logic [31:0]        status_word;
   logic               status_clear;
   logic               irq_pending;
   logic               irq_overrun;
   logic [FRAME_W-1:0] frame_count;

   assign addr_w16 = 16'(address);

   // Memory CPU-port addresses follow the request address directly; the RAMs register it.
   assign addr_tile_graphics   = addr_w16[10:0];
   assign addr_sprite_graphics = addr_w16[10:0];
   assign addr_tile_buffer     = addr_w16[8:0];
   assign addr_OAM             = addr_w16[7:0];
   assign addr_color_palettes  = addr_w16[2:0];

   // Accepted STATUS read clears the interrupt flags while its data is being muxed.
   assign status_clear = rvalid_q && (region_q == REG_STATUS);

   ppu_vblank_irq #(
      .FRAME_W(FRAME_W)
   ) u_vblank_irq (
      .clk_i        (clk),
      .rst_i        (reset),
      .vblank_i     (vblank),
      .clear_i      (status_clear),
      .pending_o    (irq_pending),
      .overrun_o    (irq_overrun),
      .frame_count_o(frame_count)
   );

   // Stage A decode and stage A+1 response mux (flags sampled before the clear lands).
   always_comb begin
      rvalid_d    = chipselect & read;
      region_d    = decode_region(addr_w16);
      status_word = '0;
      status_word[STATUS_PENDING_BIT] = irq_pending;
      status_word[STATUS_VBLANK_BIT]  = vblank;
      status_word[STATUS_OVERRUN_BIT] = irq_overrun;
      resp_data   = '0;
      case (region_q)
         REG_TGFX:   resp_data = rd_tile_graphics;
         REG_SGFX:   resp_data = rd_sprite_graphics;
         REG_TBUF:   resp_data = rd_tile_buffer;
         REG_OAM:    resp_data = rd_OAM;
         REG_PAL:    resp_data = {8'h00, rd_color_palettes};
         REG_STATUS: resp_data = status_word;
         REG_FRAME:  resp_data = 32'(frame_count);
         REG_LINE:   resp_data = {22'd0, vcount};
         default:    resp_data = '0;
      endcase
      readdatavalid_d = rvalid_q;
      readdata_d      = rvalid_q ? resp_data : readdata_q;
   end

   // Pipeline registers; reset discards anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid_q        <= 1'b0;
         region_q        <= REG_NONE;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
      end else begin
         rvalid_q        <= rvalid_d;
         region_q        <= region_d;
         readdata_q      <= readdata_d;
         readdatavalid_q <= readdatavalid_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = readdatavalid_q;
   assign irq           = irq_pending;

endmodule

// File: tb/tb_ppu_cpu_readback.sv
// Self-checking bench for ppu_cpu_readback: table-driven reads through a latency-checking
// scoreboard plus directed interrupt, reset and frame-counter wrap sequences.
module tb_ppu_cpu_readback;

   localparam int unsigned ADDR_W  = 13;
   localparam int unsigned FRAME_W = 4;

   logic              clk;
   logic              reset;
   logic              chipselect;
   logic              read;
   logic [ADDR_W-1:0] address;
   logic [31:0]       readdata;
   logic              readdatavalid;
   logic              irq;
   logic              vblank;
   logic [9:0]        vcount;
   logic [8:0]        addr_tile_buffer;
   logic [10:0]       addr_tile_graphics;
   logic [10:0]       addr_sprite_graphics;
   logic [7:0]        addr_OAM;
   logic [2:0]        addr_color_palettes;
   logic [31:0]       rd_tile_buffer;
   logic [31:0]       rd_tile_graphics;
   logic [31:0]       rd_sprite_graphics;
   logic [31:0]       rd_OAM;
   logic [23:0]       rd_color_palettes;

   logic [31:0] tgfx_mem [0:2047];
   logic [31:0] sgfx_mem [0:2047];
   logic [31:0] tbuf_mem [0:511];
   logic [31:0] oam_mem  [0:255];
   logic [23:0] pal_mem  [0:7];

   typedef struct {
      logic [15:0] addr;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      int          due;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   cyc;
   int   checks;
   int   errors;

   ppu_cpu_readback #(
      .ADDR_W (ADDR_W),
      .FRAME_W(FRAME_W)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .chipselect          (chipselect),
      .read                (read),
      .address             (address),
      .readdata            (readdata),
      .readdatavalid       (readdatavalid),
      .irq                 (irq),
      .vblank              (vblank),
      .vcount              (vcount),
      .addr_tile_buffer    (addr_tile_buffer),
      .addr_tile_graphics  (addr_tile_graphics),
      .addr_sprite_graphics(addr_sprite_graphics),
      .addr_OAM            (addr_OAM),
      .addr_color_palettes (addr_color_palettes),
      .rd_tile_buffer      (rd_tile_buffer),
      .rd_tile_graphics    (rd_tile_graphics),
      .rd_sprite_graphics  (rd_sprite_graphics),
      .rd_OAM              (rd_OAM),
      .rd_color_palettes   (rd_color_palettes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle synchronous RAM models for the CPU ports.
   always @(posedge clk) begin
      rd_tile_graphics   <= tgfx_mem[addr_tile_graphics];
      rd_sprite_graphics <= sgfx_mem[addr_sprite_graphics];
      rd_tile_buffer     <= tbuf_mem[addr_tile_buffer];
      rd_OAM             <= oam_mem[addr_OAM];
      rd_color_palettes  <= pal_mem[addr_color_palettes];
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: every valid beat must match the oldest expectation, on time.
   always @(negedge clk) begin
      if (readdatavalid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got readdata %h with no read outstanding at cycle %0d",
                     readdata, cyc);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check32($sformatf("rdata@%h", e.addr), readdata, e.data);
            check32($sformatf("latency@%h", e.addr), 32'(cyc), 32'(e.due));
         end
      end
   end

   // Present one read for a cycle; the response is due two edges later.
   task automatic issue(input logic [15:0] a, input logic [31:0] exp);
      sb_t e;
      chipselect = 1'b1;
      read       = 1'b1;
      address    = a[ADDR_W-1:0];
      e.addr     = a;
      e.data     = exp;
      e.due      = cyc + 2;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      chipselect = 1'b0;
      read       = 1'b0;
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic drain();
      chipselect = 1'b0;
      read       = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d reads outstanding required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic vblank_pulse();
      vblank = 1'b0;
      @(negedge clk);
      vblank = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      cyc        = 0;
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      chipselect = 1'b0;
      read       = 1'b0;
      address    = '0;
      vblank     = 1'b0;
      vcount     = 10'h2A5;

      for (int i = 0; i < 2048; i++) tgfx_mem[i] = 32'h1000_0000 | 32'(i);
      for (int i = 0; i < 2048; i++) sgfx_mem[i] = 32'h2000_0000 | 32'(i);
      for (int i = 0; i < 512; i++)  tbuf_mem[i] = 32'h3000_0000 | 32'(i);
      for (int i = 0; i < 256; i++)  oam_mem[i]  = 32'h4000_0000 | 32'(i * 3);
      for (int i = 0; i < 8; i++)    pal_mem[i]  = 24'hA0_0000 | 24'(i);
      tgfx_mem[5] = 32'hDEAD_BEEF;
      pal_mem[3]  = 24'h12_3456;

      vecs.push_back('{16'h0005, 32'hDEAD_BEEF});
      vecs.push_back('{16'h1303, 32'h0012_3456});
      for (int i = 0; i < 8; i++) begin
         vecs.push_back('{16'h1200 + 16'(i), 32'h4000_0000 | 32'(i * 3)});
      end
      vecs.push_back('{16'h07FF, 32'h1000_07FF});
      vecs.push_back('{16'h0800, 32'h2000_0000});
      vecs.push_back('{16'h0FFF, 32'h2000_07FF});
      vecs.push_back('{16'h1000, 32'h3000_0000});
      vecs.push_back('{16'h11FF, 32'h3000_01FF});
      vecs.push_back('{16'h12FF, 32'h4000_02FD});
      vecs.push_back('{16'h1307, 32'h00A0_0007});
      vecs.push_back('{16'h1308, 32'h0000_0000});
      vecs.push_back('{16'h13FF, 32'h0000_0000});
      vecs.push_back('{16'h1402, 32'h0000_02A5});
      vecs.push_back('{16'h1403, 32'h0000_0000});
      vecs.push_back('{16'h1500, 32'h0000_0000});
      vecs.push_back('{16'h1FFF, 32'h0000_0000});

      // Reset state.
      repeat (3) @(negedge clk);
      check32("reset_readdata", readdata, 32'h0);
      check32("reset_readdatavalid", 32'(readdatavalid), 32'h0);
      check32("reset_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      idle(2);

      // Table of reads, all back-to-back.
      foreach (vecs[i]) issue(vecs[i].addr, vecs[i].exp);
      drain();
      issue(16'h1401, 32'h0);
      issue(16'h1400, 32'h0);
      drain();

      // Read without chipselect is ignored.
      chipselect = 1'b0;
      read       = 1'b1;
      address    = 13'h0005;
      repeat (4) @(negedge clk);
      idle(2);

      // Single vblank rise, then FRAME_COUNT and a clearing STATUS read.
      vblank = 1'b1;
      @(negedge clk);
      check32("irq_after_rise", 32'(irq), 32'h1);
      issue(16'h1401, 32'h1);
      drain();
      issue(16'h1400, 32'h3);
      chipselect = 1'b0;
      read       = 1'b0;
      check32("irq_before_clear", 32'(irq), 32'h1);
      @(negedge clk);
      check32("irq_after_clear", 32'(irq), 32'h0);
      drain();

      // Two rises without a read: overrun; a second STATUS read sees it cleared.
      vblank_pulse();
      vblank_pulse();
      vblank = 1'b0;
      idle(2);
      check32("irq_two_rises", 32'(irq), 32'h1);
      issue(16'h1400, 32'h5);
      drain();
      issue(16'h1400, 32'h0);
      drain();
      check32("irq_after_overrun_clear", 32'(irq), 32'h0);

      // Clear coincides with a rise while pending: set wins, no overrun from that rise.
      vblank_pulse();
      vblank = 1'b0;
      idle(2);
      issue(16'h1400, 32'h3);
      chipselect = 1'b0;
      read       = 1'b0;
      vblank     = 1'b1;
      @(negedge clk);
      check32("irq_set_wins", 32'(irq), 32'h1);
      drain();
      issue(16'h1400, 32'h3);
      drain();
      issue(16'h1401, 32'h5);
      drain();
      check32("irq_after_coincide_clear", 32'(irq), 32'h0);

      // Reset one cycle after an accept: response dropped, state cleared.
      vblank_pulse();
      check32("irq_before_reset", 32'(irq), 32'h1);
      issue(16'h1401, 32'h6);
      chipselect = 1'b0;
      read       = 1'b0;
      reset      = 1'b1;
      sb.delete();
      @(negedge clk);
      check32("irq_in_reset", 32'(irq), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle(4);
      check32("irq_no_rise_after_reset", 32'(irq), 32'h0);
      issue(16'h1401, 32'h0);
      drain();

      // Frame counter wrap at 2^FRAME_W.
      for (int i = 0; i < 15; i++) vblank_pulse();
      idle(1);
      issue(16'h1401, 32'hF);
      drain();
      vblank_pulse();
      idle(1);
      issue(16'h1401, 32'h0);
      drain();
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish required finish before 200000");
      $fatal(1);
   end

endmodule
